// File: rtl/axi_wr_sched.sv
// axi_wr_sched: round-robin scheduler of NUM_REQ link-header producers onto one single-beat AXI write path.
// Optional macro WR_RESP_CHK_EN adds B-channel error counting (err_cnt, err_flag).
module axi_wr_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned RING_SLOTS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   base_addr,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [31:0]                   AWADDR,
    output logic [3:0]                    AWID,
    output logic                          WVALID,
    input  logic                          WREADY,
    output logic [DATA_W-1:0]             WDATA,
    output logic [DATA_W/8-1:0]           WSTRB,
    output logic                          WLAST,
    output logic [3:0]                    WID,
    input  logic                          BVALID,
    output logic                          BREADY,
    input  logic [1:0]                    BRESP,
    input  logic [3:0]                    BID,
    output logic [$clog2(RING_SLOTS)-1:0] slot_ptr,
    output logic                          busy
`ifdef WR_RESP_CHK_EN
    ,
    output logic [15:0]                   err_cnt,
    output logic                          err_flag
`endif
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned SUM_W  = IDX_W + 1;
    localparam int unsigned SLOT_W = $clog2(RING_SLOTS);

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RESP} state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_awid;
    logic [31:0]         r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_busy;
    logic [SLOT_W-1:0]   r_slot_ptr;

    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic [SUM_W-1:0]    w_scan_idx;
    logic [DATA_W-1:0]   w_word;
    logic [IDX_W-1:0]    w_next_rr;
    logic                w_aw_done;
    logic                w_w_done;
    logic [31:0]         w_slot_off;

    // Round-robin scan: lowest offset from r_rr_ptr wins, so walk offsets high to low.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan_idx = SUM_W'(r_rr_ptr) + SUM_W'(k);
            if (w_scan_idx >= SUM_W'(NUM_REQ)) begin
                w_scan_idx = w_scan_idx - SUM_W'(NUM_REQ);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && (w_scan_idx == SUM_W'(i))) begin
                    w_found  = 1'b1;
                    w_winner = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        w_word    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_word = req_data[i*DATA_W +: DATA_W];
                if ((r_state == ST_IDLE) && w_found) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    assign w_next_rr  = (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + IDX_W'(1);
    assign w_aw_done  = !r_awvalid || AWREADY;
    assign w_w_done   = !r_wvalid || WREADY;
    assign w_slot_off = 32'({r_slot_ptr, 3'b000});

`ifdef WR_RESP_CHK_EN
    logic [15:0] r_err_cnt;
    logic        r_err_flag;
    logic        w_b_err;
    assign w_b_err  = (BRESP != 2'b00) || (BID != r_awid);
    assign err_cnt  = r_err_cnt;
    assign err_flag = r_err_flag;
`else
    logic w_unused_b;
    assign w_unused_b = ^{BRESP, BID};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_awid     <= '0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_busy     <= 1'b0;
            r_slot_ptr <= '0;
`ifdef WR_RESP_CHK_EN
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_wdata   <= w_word;
                        r_awid    <= w_winner;
                        r_awaddr  <= base_addr + w_slot_off;
                        r_rr_ptr  <= w_next_rr;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (r_awvalid && AWREADY) r_awvalid <= 1'b0;
                    if (r_wvalid && WREADY)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (BVALID) begin
                        r_bready   <= 1'b0;
                        r_slot_ptr <= r_slot_ptr + SLOT_W'(1);
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
`ifdef WR_RESP_CHK_EN
                        if (w_b_err) begin
                            r_err_flag <= 1'b1;
                            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                        end
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign AWVALID  = r_awvalid;
    assign AWADDR   = r_awaddr;
    assign AWID     = r_awid;
    assign WVALID   = r_wvalid;
    assign WDATA    = r_wdata;
    assign WSTRB    = '1;
    assign WLAST    = 1'b1;
    assign WID      = r_awid;
    assign BREADY   = r_bready;
    assign slot_ptr = r_slot_ptr;
    assign busy     = r_busy;

endmodule

// File: tb/tb_axi_wr_sched.sv
// Directed bench for axi_wr_sched: scoreboard of expected AW/W beats, slave handshakes driven inline.
// Error-counter checks compile in when WR_RESP_CHK_EN is defined.
module tb_axi_wr_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 64;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [63:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      base_addr;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY, busy;
    logic [31:0]      AWADDR;
    logic [3:0]       AWID, WID, BID;
    logic [DW-1:0]    WDATA;
    logic [DW/8-1:0]  WSTRB;
    logic [1:0]       BRESP;
    logic [3:0]       slot_ptr;
`ifdef WR_RESP_CHK_EN
    logic [15:0]      err_cnt;
    logic             err_flag;
`endif

    logic [DW-1:0]    rdata [NR];
    exp_t             sb_q[$];
    int               checks = 0;
    int               errors = 0;
    int               exp_slot = 0;
    int               push_slot = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = rdata[i];
    end

    axi_wr_sched dut (
        .clk(clk), .rst(rst), .base_addr(base_addr),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .WLAST(WLAST), .WID(WID),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
        .slot_ptr(slot_ptr), .busy(busy)
`ifdef WR_RESP_CHK_EN
        , .err_cnt(err_cnt), .err_flag(err_flag)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id   = 4'(id);
        e.addr = base_addr + 32'((push_slot % 16) * 8);
        e.data = rdata[id];
        sb_q.push_back(e);
        push_slot++;
    endtask

    // Entered in IDLE with the winner's valid already driven; leaves the DUT in RESP.
    task automatic serve_xfer(input int aw_wait, input int w_wait, input bit drop);
        exp_t        e;
        logic [63:0] held;
        int          n;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow observed=empty expected=entry");
            return;
        end
        e = sb_q.pop_front();
        check("req_ready", 64'(req_ready), 64'(1) << e.id);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!AWVALID && n < 20);
        check("awvalid", 64'(AWVALID), 64'(1));
        if (drop) req_valid = '0;
        check("awid", 64'(AWID), 64'(e.id));
        check("wid", 64'(WID), 64'(e.id));
        check("awaddr", 64'(AWADDR), 64'(e.addr));
        check("wdata", WDATA, e.data);
        check("busy_xfer", 64'(busy), 64'(1));
        held = WDATA;
        n = 0;
        while ((AWVALID || WVALID) && n < 40) begin
            AWREADY = AWVALID && (n >= aw_wait);
            WREADY  = WVALID && (n >= w_wait);
            cyc();
            n++;
            if (AWVALID || WVALID) begin
                check("bready_early", 64'(BREADY), 64'(0));
                check("no_grant_xfer", 64'(req_ready), 64'(0));
                if (WVALID) check("wdata_hold", WDATA, held);
                if (AWVALID) check("awaddr_hold", 64'(AWADDR), 64'(e.addr));
            end
        end
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        check("xfer_done", 64'({AWVALID, WVALID}), 64'(0));
        check("resp_bready", 64'(BREADY), 64'(1));
    endtask

    task automatic serve_b(input int b_delay, input logic [1:0] resp, input logic [3:0] bid);
        for (int d = 0; d < b_delay; d++) begin
            cyc();
            check("bready_wait", 64'(BREADY), 64'(1));
            check("no_grant_resp", 64'(req_ready), 64'(0));
        end
        BVALID = 1'b1;
        BRESP  = resp;
        BID    = bid;
        cyc();
        BVALID = 1'b0;
        BRESP  = 2'b00;
        BID    = 4'd0;
        exp_slot = (exp_slot + 1) % 16;
        check("bready_drop", 64'(BREADY), 64'(0));
        check("slot_ptr", 64'(slot_ptr), 64'(exp_slot));
        check("busy_idle", 64'(busy), 64'(0));
    endtask

    task automatic single(input int id, input int aw_wait, input int w_wait);
        req_valid = 4'b0001 << id;
        #1;
        push_exp(id);
        serve_xfer(aw_wait, w_wait, 1'b1);
        serve_b(0, 2'b00, 4'(id));
    endtask

    initial begin
        rst = 1'b1; base_addr = '0; req_valid = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00; BID = 4'd0;
        for (int i = 0; i < NR; i++) rdata[i] = 64'hD0D0_0000_0000_0000 | 64'(i);
        repeat (3) cyc();
        check("rst_awvalid", 64'(AWVALID), 64'(0));
        check("rst_wvalid", 64'(WVALID), 64'(0));
        check("rst_bready", 64'(BREADY), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_awaddr", 64'(AWADDR), 64'(0));
        check("rst_wdata", WDATA, 64'(0));
        check("rst_awid", 64'(AWID), 64'(0));
        check("rst_slot", 64'(slot_ptr), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("wstrb", 64'(WSTRB), 64'hFF);
        check("wlast", 64'(WLAST), 64'(1));
`ifdef WR_RESP_CHK_EN
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        check("rst_err_flag", 64'(err_flag), 64'(0));
`endif
        rst = 1'b0;
        cyc();

        // Single req0 word at a high base.
        base_addr = 32'hFFFF_0008;
        rdata[0]  = 64'hA5A5_0000_0000_0001;
        single(0, 0, 0);

        // All requesters valid: grants rotate starting after req0.
        base_addr = 32'h1000_0000;
        rdata[0]  = 64'hD0D0_0000_0000_0000;
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 8; k++) push_exp((k + 1) % 4);
        for (int k = 0; k < 8; k++) begin
            serve_xfer(k % 3, (k + 1) % 3, k == 7);
            serve_b(k % 2, 2'b00, 4'((k + 1) % 4));
        end

        // Ring wrap and 32-bit address carry drop.
        base_addr = 32'hFFFF_FFF8;
        for (int k = 0; k < 17; k++) single(k % 4, 0, 0);

        // W stalled behind AW, then AW stalled and a long B wait with another requester pending.
        base_addr = 32'h2000_0000;
        single(1, 0, 5);
        req_valid = 4'b0100;
        #1;
        push_exp(2);
        serve_xfer(3, 0, 1'b1);
        req_valid = 4'b1000;
        serve_b(3, 2'b00, 4'd2);
        push_exp(3);
        serve_xfer(0, 0, 1'b1);
        serve_b(0, 2'b00, 4'd3);

        // Reset while waiting for B.
        base_addr = 32'h3000_0000;
        req_valid = 4'b0010;
        #1;
        push_exp(1);
        serve_xfer(0, 0, 1'b1);
        rst = 1'b1;
        cyc();
        check("mid_rst_awvalid", 64'(AWVALID), 64'(0));
        check("mid_rst_wvalid", 64'(WVALID), 64'(0));
        check("mid_rst_bready", 64'(BREADY), 64'(0));
        check("mid_rst_awaddr", 64'(AWADDR), 64'(0));
        check("mid_rst_wdata", WDATA, 64'(0));
        check("mid_rst_awid", 64'(AWID), 64'(0));
        check("mid_rst_wid", 64'(WID), 64'(0));
        check("mid_rst_slot", 64'(slot_ptr), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        exp_slot  = 0;
        push_slot = 0;
        req_valid = 4'b1001;
        #1;
        push_exp(0);
        serve_xfer(0, 0, 1'b1);
        serve_b(0, 2'b00, 4'd0);

`ifdef WR_RESP_CHK_EN
        check("err_cnt_clean", 64'(err_cnt), 64'(0));
        req_valid = 4'b0010;
        #1;
        push_exp(1);
        serve_xfer(0, 0, 1'b1);
        serve_b(0, 2'b10, 4'd1);
        check("err_cnt_bresp", 64'(err_cnt), 64'(1));
        check("err_flag_bresp", 64'(err_flag), 64'(1));
        req_valid = 4'b0100;
        #1;
        push_exp(2);
        serve_xfer(0, 0, 1'b1);
        serve_b(0, 2'b00, 4'd5);
        check("err_cnt_bid", 64'(err_cnt), 64'(2));
        single(3, 0, 0);
        check("err_cnt_hold", 64'(err_cnt), 64'(2));
        check("err_flag_hold", 64'(err_flag), 64'(1));
`endif

        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
